// File: rtl/width_splitter_if.sv
// rtl/width_splitter_if.sv - wide-word in / narrow-beat out handshake bundle for width_splitter
interface width_splitter_if #(
  parameter int DW    = 8,
  parameter int RATIO = 4
);
  localparam int CW = $clog2(RATIO);

  logic [DW*RATIO-1:0] in_data_i;
  logic [CW-1:0]       in_cnt_i;
  logic                in_vld_i;
  logic                in_ready_o;
  logic [DW-1:0]       out_data_o;
  logic                out_last_o;
  logic                out_vld_o;
  logic                out_ready_i;

  // slave: the splitter itself; master: the surrounding upstream/downstream logic
  modport slave (
    input  in_data_i, in_cnt_i, in_vld_i, out_ready_i,
    output in_ready_o, out_data_o, out_last_o, out_vld_o
  );

  modport master (
    output in_data_i, in_cnt_i, in_vld_i, out_ready_i,
    input  in_ready_o, out_data_o, out_last_o, out_vld_o
  );
endinterface

// File: rtl/width_splitter.sv
// rtl/width_splitter.sv - splits a DW*RATIO word into up to RATIO registered DW-bit beats
module width_splitter #(
  parameter int DW    = 8,
  parameter int RATIO = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  width_splitter_if.slave  bus
);
  localparam int CW = $clog2(RATIO);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state;
  logic [DW-1:0]       data_q;
  logic                last_q;
  logic [CW-1:0]       idx_q;
  logic [CW-1:0]       cnt_q;
  logic [DW*RATIO-1:0] word_q;

  logic [DW-1:0]       beats [RATIO];
  logic [CW-1:0]       idx_nxt;
  logic                accept;
  logic                take;

  for (genvar k = 0; k < RATIO; k++) begin : g_beat
    assign beats[k] = word_q[k*DW +: DW];
  end

  assign idx_nxt = idx_q + CW'(1);

  // out_ready_i -> in_ready_o is the only combinational path through the block
  assign bus.in_ready_o = (state == IDLE) | (bus.out_ready_i & last_q);
  assign accept         = bus.in_vld_i & bus.in_ready_o;
  assign take           = (state == SEND) & bus.out_ready_i;

  assign bus.out_vld_o  = (state == SEND);
  assign bus.out_data_o = data_q;
  assign bus.out_last_o = last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      data_q <= '0;
      last_q <= 1'b0;
      idx_q  <= '0;
      cnt_q  <= '0;
      word_q <= '0;
    end else if (accept) begin
      // covers both an idle accept and the no-bubble hand-over after the last beat
      state  <= SEND;
      data_q <= bus.in_data_i[DW-1:0];
      last_q <= (bus.in_cnt_i == '0);
      idx_q  <= '0;
      cnt_q  <= bus.in_cnt_i;
      word_q <= bus.in_data_i;
    end else if (take) begin
      if (last_q) begin
        state  <= IDLE;
        last_q <= 1'b0;
      end else begin
        idx_q  <= idx_nxt;
        data_q <= beats[idx_nxt];
        last_q <= (idx_nxt == cnt_q);
      end
    end
  end
endmodule

// File: tb/tb_width_splitter.sv
// tb/tb_width_splitter.sv - self-checking bench for width_splitter (DW=8, RATIO=4)
module tb_width_splitter;
  localparam int DW    = 8;
  localparam int RATIO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  width_splitter_if #(.DW(DW), .RATIO(RATIO)) bus ();

  width_splitter #(.DW(DW), .RATIO(RATIO)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  cnt;
    logic [31:0] exp_beats;
    int          n;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  vec_t  tbl [4];
  beat_t q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic v, input logic [7:0] d, input logic l);
    chk({name, ".vld"},  bus.out_vld_o,  v);
    chk({name, ".data"}, bus.out_data_o, d);
    chk({name, ".last"}, bus.out_last_o, l);
  endtask

  initial begin
    logic [7:0]  ed   [5];
    logic        el   [5];
    int          words;
    int          lasts;
    logic [7:0]  prev_d;
    logic        prev_l;
    logic        prev_stall;
    logic        exp_rdy;
    logic        do_pop;
    logic        do_acc;
    logic [31:0] rd;
    logic [1:0]  rc;

    tbl[0] = '{32'h44332211, 2'd3, 32'h44332211, 4};
    tbl[1] = '{32'hDDCCBBAA, 2'd0, 32'h000000AA, 1};
    tbl[2] = '{32'hF0E0D0C0, 2'd1, 32'h0000D0C0, 2};
    tbl[3] = '{32'h13579BDF, 2'd2, 32'h00579BDF, 3};

    bus.in_data_i   = '0;
    bus.in_cnt_i    = '0;
    bus.in_vld_i    = 1'b0;
    bus.out_ready_i = 1'b0;

    #12;
    chk_out("reset", 1'b0, 8'h00, 1'b0);
    chk("reset.in_ready", bus.in_ready_o, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven words with a free-running sink
    for (int t = 0; t < 4; t++) begin
      tick();
      bus.in_vld_i    = 1'b1;
      bus.in_data_i   = tbl[t].data;
      bus.in_cnt_i    = tbl[t].cnt;
      bus.out_ready_i = 1'b1;
      #1;
      chk($sformatf("tbl%0d.accept_ready", t), bus.in_ready_o, 1'b1);
      tick();
      bus.in_vld_i  = 1'b0;
      bus.in_data_i = $urandom;
      bus.in_cnt_i  = 2'($urandom);
      #1;
      for (int k = 0; k < tbl[t].n; k++) begin
        chk_out($sformatf("tbl%0d.beat%0d", t, k), 1'b1, tbl[t].exp_beats[k*8 +: 8], k == tbl[t].n - 1);
        chk($sformatf("tbl%0d.beat%0d.in_ready", t, k), bus.in_ready_o, k == tbl[t].n - 1);
        tick();
      end
      chk_out($sformatf("tbl%0d.idle", t), 1'b0, tbl[t].exp_beats[(tbl[t].n-1)*8 +: 8], 1'b0);
    end

    // back-to-back: A(cnt=1) then B(cnt=2) held valid, no gap between words
    ed = '{8'h01, 8'h02, 8'h09, 8'h0A, 8'h0B};
    el = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bus.in_vld_i    = 1'b1;
    bus.in_data_i   = 32'h04030201;
    bus.in_cnt_i    = 2'd1;
    bus.out_ready_i = 1'b1;
    tick();
    bus.in_data_i = 32'h0C0B0A09;
    bus.in_cnt_i  = 2'd2;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) bus.in_vld_i = 1'b0;
      chk_out($sformatf("b2b.beat%0d", k), 1'b1, ed[k], el[k]);
      tick();
    end
    chk("b2b.end_vld", bus.out_vld_o, 1'b0);

    // backpressure while 0x22 is presented
    bus.in_vld_i  = 1'b1;
    bus.in_data_i = 32'h44332211;
    bus.in_cnt_i  = 2'd3;
    tick();
    bus.in_vld_i = 1'b0;
    chk_out("bp.beat0", 1'b1, 8'h11, 1'b0);
    tick();
    bus.out_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk_out($sformatf("bp.stall%0d", c), 1'b1, 8'h22, 1'b0);
      chk($sformatf("bp.stall%0d.in_ready", c), bus.in_ready_o, 1'b0);
      tick();
    end
    chk_out("bp.stall_end", 1'b1, 8'h22, 1'b0);
    bus.out_ready_i = 1'b1;
    tick();
    chk_out("bp.beat2", 1'b1, 8'h33, 1'b0);
    tick();
    chk_out("bp.beat3", 1'b1, 8'h44, 1'b1);
    tick();

    // asynchronous reset mid-word
    bus.in_vld_i  = 1'b1;
    bus.in_data_i = 32'h44332211;
    bus.in_cnt_i  = 2'd3;
    tick();
    bus.in_vld_i = 1'b0;
    tick();
    tick();
    chk_out("rst.pre", 1'b1, 8'h33, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst.async", 1'b0, 8'h00, 1'b0);
    chk("rst.in_ready", bus.in_ready_o, 1'b1);
    bus.in_vld_i  = 1'b1;
    bus.in_data_i = 32'hDEADBEEF;
    tick();
    chk("rst.no_accept", bus.out_vld_o, 1'b0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.in_data_i = 32'h88776655;
    bus.in_cnt_i  = 2'd3;
    tick();
    bus.in_vld_i = 1'b0;
    chk_out("rst.restart", 1'b1, 8'h55, 1'b0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk_out($sformatf("rst.beat%0d", k), 1'b1, 8'h55 + 8'(k * 8'h11), k == 3);
    end
    tick();
    chk("rst.drained", bus.out_vld_o, 1'b0);

    // randomized stress against a queue-of-beats reference
    q.delete();
    words      = 0;
    lasts      = 0;
    prev_stall = 1'b0;
    prev_d     = '0;
    prev_l     = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rd = $urandom;
      rc = 2'($urandom);
      bus.in_data_i   = rd;
      bus.in_cnt_i    = rc;
      bus.in_vld_i    = (cyc < 580) ? ($urandom_range(0, 1) == 1) : 1'b0;
      bus.out_ready_i = (cyc < 580) ? ($urandom_range(0, 9) < 7) : 1'b1;
      #1;
      exp_rdy = (q.size() == 0) || (bus.out_ready_i && q.size() == 1);
      chk("rnd.in_ready", bus.in_ready_o, exp_rdy);
      if (q.size() == 0) begin
        chk("rnd.idle_vld", bus.out_vld_o, 1'b0);
      end else begin
        chk_out("rnd.beat", 1'b1, q[0].d, q[0].l);
      end
      if (prev_stall) begin
        chk("rnd.stall_hold", {bus.out_vld_o, bus.out_last_o, bus.out_data_o}, {1'b1, prev_l, prev_d});
      end
      do_pop = bus.out_ready_i && (q.size() != 0);
      do_acc = bus.in_vld_i && exp_rdy;
      if (do_pop && bus.out_vld_o && bus.out_last_o) lasts++;
      prev_stall = bus.out_vld_o && !bus.out_ready_i;
      prev_d     = bus.out_data_o;
      prev_l     = bus.out_last_o;
      @(posedge clk);
      if (do_pop) void'(q.pop_front());
      if (do_acc) begin
        words++;
        for (int k = 0; k <= int'(rc); k++) q.push_back('{rd[k*8 +: 8], k == int'(rc)});
      end
      #1;
    end
    chk("rnd.queue_empty", q.size(), 0);
    chk("rnd.one_last_per_word", lasts, words);
    checks++;
    if (words < 20) begin
      errors++;
      $display("FAIL rnd.word_count actual=%0d required>=20", words);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
